// File: rtl/sequence_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_pkg
//  Description : Shared FSM state encoding, default widths and len clamping
//                helper for the serial sequence generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sequence_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = $clog2(DEF_PAT_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A len of zero or one wider than the pattern means "the whole pattern".
    function automatic int eff_len(input int len, input int pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage : sequence_pkg
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_reg
//  Description : Parallel-load, LSB-first shifter with a bit index counter.
//                Exposes the bit that will be current after the coming edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_reg #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_next_bit,
    output logic             o_last
);

    logic [PAT_W-1:0] r_data;
    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[PAT_W-1:1]};
            r_cnt  <= r_cnt + LEN_W'(1);
        end
    end

    // Lookahead lets the caller register the serial output in the same edge.
    always_comb begin
        if (i_load) begin
            o_next_bit = i_data[0];
        end else if (i_shift) begin
            o_next_bit = r_data[1];
        end else begin
            o_next_bit = r_data[0];
        end
    end

    assign o_last = (r_cnt == (i_len - LEN_W'(1)));

endmodule : seq_shift_reg
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_generator
//  Description : Serialises a captured pattern LSB first, repeated 1..4 times
//                with optional idle gaps, framed and followed by a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_generator
    import sequence_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       reps,
    input  logic [3:0]       gap,
    output logic             ready,
    output logic             aout,
    output logic             avalid,
    output logic             frame,
    output logic             done,
    output logic [1:0]       count
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [1:0]       r_reps;
    logic [3:0]       r_gap;
    logic [1:0]       r_rep;
    logic [3:0]       r_gcnt;

    logic             r_ready;
    logic             r_aout;
    logic             r_avalid;
    logic             r_frame;
    logic             r_done;

    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_new_rep;
    logic             w_last;
    logic             w_next_bit;
    logic             w_rep_done;
    logic [LEN_W-1:0] w_len_eff;
    logic [PAT_W-1:0] w_ld_data;

    logic             w_ready_nxt;
    logic             w_aout_nxt;
    logic             w_avalid_nxt;
    logic             w_frame_nxt;
    logic             w_done_nxt;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_rep_done = (r_rep == r_reps);
    assign w_len_eff  = LEN_W'(eff_len(int'(len), PAT_W));
    assign w_ld_data  = (r_state == ST_IDLE) ? pattern : r_pat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_last) begin
                    if (w_rep_done) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_gap != 4'd0) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (r_gcnt == (r_gap - 4'd1)) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values the registered outputs take after this edge
    // ------------------------------------------------------------------
    always_comb begin
        w_load    = w_accept
                  || ((w_state_nxt == ST_SEND)
                      && ((r_state == ST_GAP) || ((r_state == ST_SEND) && w_last)));
        w_shift   = (r_state == ST_SEND) && !w_last;
        w_new_rep = w_load && (r_state != ST_IDLE);

        w_ready_nxt  = (w_state_nxt == ST_IDLE);
        w_avalid_nxt = (w_state_nxt == ST_SEND);
        w_aout_nxt   = w_avalid_nxt && w_next_bit;
        w_frame_nxt  = w_load;
        w_done_nxt   = (w_state_nxt == ST_DONE);
    end

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (w_ld_data),
        .i_len      (r_len),
        .o_next_bit (w_next_bit),
        .o_last     (w_last)
    );

    // Transfer parameters are frozen at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat  <= '0;
            r_len  <= LEN_W'(PAT_W);
            r_reps <= 2'd0;
            r_gap  <= 4'd0;
        end else if (w_accept) begin
            r_pat  <= pattern;
            r_len  <= w_len_eff;
            r_reps <= reps;
            r_gap  <= gap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep  <= 2'd0;
            r_gcnt <= 4'd0;
        end else begin
            if (w_accept || (r_state == ST_DONE)) begin
                r_rep <= 2'd0;
            end else if (w_new_rep) begin
                r_rep <= r_rep + 2'd1;
            end
            r_gcnt <= (r_state == ST_GAP) ? (r_gcnt + 4'd1) : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b1;
            r_aout   <= 1'b0;
            r_avalid <= 1'b0;
            r_frame  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_aout   <= w_aout_nxt;
            r_avalid <= w_avalid_nxt;
            r_frame  <= w_frame_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign ready  = r_ready;
    assign aout   = r_aout;
    assign avalid = r_avalid;
    assign frame  = r_frame;
    assign done   = r_done;
    assign count  = r_rep;

endmodule : sequence_generator
`default_nettype wire

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 8, pattern register width in bits (2..16).
REQ-002 Parameter LEN_W, default $clog2(PAT_W)+1, width of the len port.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  transmit request; accepted only in a cycle where ready=1.
REQ-006 pattern  input  PAT_W  bits to emit, LSB first.
REQ-007 len  input  LEN_W  bits per repetition; 0 or values above PAT_W SHALL be treated as PAT_W.
REQ-008 reps  input  2  repetition count minus one (1..4 repetitions).
REQ-009 gap  input  4  idle cycles inserted between repetitions (0..15).
REQ-010 ready  output  1  high only in IDLE.
REQ-011 aout  output  1  serial data bit, registered.
REQ-012 avalid  output  1  aout carries a pattern bit this cycle.
REQ-013 frame  output  1  high with the first bit of every repetition.
REQ-014 done  output  1  one-cycle pulse after the last bit of the last repetition.
REQ-015 count  output  2  index of the current repetition (0-based); holds its last value in DONE and returns to 0 in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SEND, GAP and DONE.
REQ-017 Acceptance (start=1 and ready=1 at edge t) SHALL capture pattern, effective len, reps and gap; later input changes SHALL have no effect until the next acceptance.
REQ-018 Bit k of the repetition SHALL appear on aout with avalid=1 in cycle t+1+k; the first bit SHALL appear exactly one cycle after acceptance.
REQ-019 After bit len-1, SEND SHALL go to GAP when repetitions remain and gap>0, directly to the next repetition's bit 0 when gap=0, and to DONE when none remain.
REQ-020 GAP SHALL last exactly gap cycles with avalid=0, aout=0 and frame=0.
REQ-021 For L=len, R=reps+1 and G=gap, done SHALL assert in cycle t+1+R*L+(R-1)*G, and ready SHALL return in the following cycle.
REQ-022 Whenever avalid=0, aout SHALL be 0.
REQ-023 start SHALL be ignored in SEND, GAP and DONE; no queuing.
REQ-024 start held high continuously SHALL cause back-to-back transfers separated only by the DONE and IDLE cycles.
REQ-025 With len=1, frame and avalid SHALL both be high for every emitted bit.

Reset
REQ-026 Reset SHALL force IDLE on the next edge with ready=1 and aout=avalid=frame=done=0, count=0, regardless of the current state.
REQ-027 Reset asserted together with start SHALL take priority; that start is not accepted.

Structure
REQ-028 Package sequence_pkg SHALL hold the FSM state enum and the default PAT_W and LEN_W constants.
REQ-029 A sub-module seq_shift_reg (PAT_W-bit parallel-load, LSB-first shifter with bit counter) SHALL be instantiated for the serialiser.

Verification
REQ-030 pattern=8'b1011_0010, len=8, reps=0, gap=0, start at t -> aout 0,1,0,0,1,1,0,1 in cycles t+1..t+8; frame only at t+1; done at t+9; ready at t+10.
REQ-031 pattern=8'b0000_0111, len=3, reps=2, gap=2 -> three 1,1,1 bursts separated by 2 idle cycles; count 0,1,2; done at t+14.
REQ-032 len=0, pattern=8'hA5 -> 8 bits emitted; same cycle count as len=8.
REQ-033 reset pulsed mid-SEND at bit 3 -> next cycle ready=1, avalid=0, count=0; no done pulse.
REQ-034 start pulsed during GAP, and pattern changed mid-transfer -> output stream unchanged; no second transfer.
REQ-035 len=1, reps=3, gap=0, pattern LSB=1 -> four consecutive cycles with aout=avalid=frame=1; done on the fifth cycle.
